// File: rtl/elevator_call_scheduler_if.sv
// Purpose: groups the call/feedback/command signals between the elevator call
//          scheduler and the car model into one bundle.
// Signals:
//   call_req      call request per floor (one-cycle pulse is enough)
//   which_floor   current floor reported by the car
//   state         car command: 2'b00 Stop, 2'b11 Up, 2'b01 Down
//   pending_calls latched, not-yet-served calls
//   door_open     high while dwelling at a floor
//   served        one-cycle pulse on the floor just served
//   fault         car reported an out-of-range floor (sticky)
// Modports:
//   master  scheduler side (drives command and status)
//   slave   car / requester side (drives calls and floor feedback)
interface elevator_call_scheduler_if #(
    parameter int NUM_FLOORS = 5,
    parameter int FLOOR_W    = 5
);
    logic [NUM_FLOORS-1:0] call_req;
    logic [FLOOR_W-1:0]    which_floor;
    logic [1:0]            state;
    logic [NUM_FLOORS-1:0] pending_calls;
    logic                  door_open;
    logic [NUM_FLOORS-1:0] served;
    logic                  fault;

    modport master (
        input  call_req,
        input  which_floor,
        output state,
        output pending_calls,
        output door_open,
        output served,
        output fault
    );

    modport slave (
        output call_req,
        output which_floor,
        input  state,
        input  pending_calls,
        input  door_open,
        input  served,
        input  fault
    );
endinterface

// File: rtl/elevator_call_scheduler.sv
// Purpose: collective SCAN scheduler for a single elevator car. Latches floor
//          calls, keeps travelling in the current direction while calls remain
//          ahead, stops at every called floor for a fixed door dwell, then
//          re-evaluates. The car applies the registered command on the
//          following negedge, so each Up/Down cycle moves it exactly one floor.
// Ports:
//   clk_i   clock, all logic on posedge
//   rst_ni  synchronous active-low reset
//   bus     elevator_call_scheduler_if.master (calls, floor feedback,
//           command, pending/served/door/fault status)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | car stopped, door closed, choosing the next direction
// MOVE_UP   | commanding Up one floor per cycle
// MOVE_DOWN | commanding Down one floor per cycle
// DOOR      | stopped with door open, dwell counter running
module elevator_call_scheduler #(
    parameter int NUM_FLOORS  = 5,
    parameter int FLOOR_W     = 5,
    parameter int DOOR_CYCLES = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    elevator_call_scheduler_if.master     bus
);

    localparam int CNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DOOR_CYCLES - 1);

    localparam logic [1:0] CMD_STOP = 2'b00;
    localparam logic [1:0] CMD_UP   = 2'b11;
    localparam logic [1:0] CMD_DOWN = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR
    } fsm_t;

    fsm_t                  fsm_q;
    logic [1:0]            cmd_q;
    logic [NUM_FLOORS-1:0] pending_q;
    logic [NUM_FLOORS-1:0] served_q;
    logic                  door_q;
    logic                  fault_q;
    logic                  last_dir_up_q;
    logic [CNT_W-1:0]      cnt_q;

    logic [NUM_FLOORS-1:0] req;
    logic [NUM_FLOORS-1:0] here_mask;
    logic                  here;
    logic                  call_here;
    logic                  above;
    logic                  below;
    logic                  floor_bad;
    logic                  go_door;

    // Decisions look at pending | incoming so a call arriving on a decision
    // cycle is honoured immediately. here_mask stays zero for an out-of-range
    // floor, which is handled by the fault path anyway.
    always_comb begin
        req       = pending_q | bus.call_req;
        here_mask = '0;
        here      = 1'b0;
        call_here = 1'b0;
        above     = 1'b0;
        below     = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(bus.which_floor)) begin
                above = above | req[i];
            end
            if (i < int'(bus.which_floor)) begin
                below = below | req[i];
            end
            if (i == int'(bus.which_floor)) begin
                here_mask[i] = 1'b1;
                here         = req[i];
                call_here    = bus.call_req[i];
            end
        end
        floor_bad = int'(bus.which_floor) >= NUM_FLOORS;
        go_door   = (fsm_q != DOOR) && here;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fsm_q         <= IDLE;
            cmd_q         <= CMD_STOP;
            pending_q     <= '0;
            served_q      <= '0;
            door_q        <= 1'b0;
            fault_q       <= 1'b0;
            last_dir_up_q <= 1'b1;
            cnt_q         <= '0;
        end else begin
            served_q  <= '0;
            pending_q <= req;
            if (fault_q || floor_bad) begin
                // Calls keep latching, but the car is parked until reset.
                fault_q <= 1'b1;
                fsm_q   <= IDLE;
                cmd_q   <= CMD_STOP;
                door_q  <= 1'b0;
                cnt_q   <= '0;
            end else if (go_door) begin
                fsm_q     <= DOOR;
                cmd_q     <= CMD_STOP;
                door_q    <= 1'b1;
                served_q  <= here_mask;
                pending_q <= req & ~here_mask;
                cnt_q     <= CNT_RELOAD;
                if (fsm_q == MOVE_UP) begin
                    last_dir_up_q <= 1'b1;
                end else if (fsm_q == MOVE_DOWN) begin
                    last_dir_up_q <= 1'b0;
                end
            end else begin
                case (fsm_q)
                    IDLE: begin
                        if (above && (last_dir_up_q || !below)) begin
                            fsm_q <= MOVE_UP;
                            cmd_q <= CMD_UP;
                        end else if (below) begin
                            fsm_q <= MOVE_DOWN;
                            cmd_q <= CMD_DOWN;
                        end else begin
                            cmd_q <= CMD_STOP;
                        end
                    end
                    MOVE_UP: begin
                        if (above) begin
                            cmd_q <= CMD_UP;
                        end else if (below) begin
                            fsm_q <= MOVE_DOWN;
                            cmd_q <= CMD_DOWN;
                        end else begin
                            fsm_q <= IDLE;
                            cmd_q <= CMD_STOP;
                        end
                    end
                    MOVE_DOWN: begin
                        if (below) begin
                            cmd_q <= CMD_DOWN;
                        end else if (above) begin
                            fsm_q <= MOVE_UP;
                            cmd_q <= CMD_UP;
                        end else begin
                            fsm_q <= IDLE;
                            cmd_q <= CMD_STOP;
                        end
                    end
                    DOOR: begin
                        // A re-press of the current floor restarts the dwell
                        // and is acknowledged rather than latched.
                        pending_q <= req & ~here_mask;
                        if (call_here) begin
                            cnt_q    <= CNT_RELOAD;
                            served_q <= here_mask;
                        end else if (cnt_q == '0) begin
                            fsm_q  <= IDLE;
                            door_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    default: begin
                        fsm_q <= IDLE;
                        cmd_q <= CMD_STOP;
                    end
                endcase
            end
        end
    end

    assign bus.state         = cmd_q;
    assign bus.pending_calls = pending_q;
    assign bus.door_open     = door_q;
    assign bus.served        = served_q;
    assign bus.fault         = fault_q;

endmodule
